// File: rtl/vec3_norm_unit.sv
`default_nettype none
// =====================================================================
// vec3_norm_unit : length or squared length of a signed fixed-point
//                  3-vector, bit-serial restoring square root
// Revision       : 1.0
// =====================================================================
module vec3_norm_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ROUND      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] vec_x,
    input  logic [DATA_WIDTH-1:0] vec_y,
    input  logic [DATA_WIDTH-1:0] vec_z,
    input  logic                  sq_mode,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] length,
    output logic                  valid_out,
    input  logic                  ready_out
);
    localparam int SW = 2 * DATA_WIDTH;
    localparam int RW = DATA_WIDTH + 2;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic                         sq_q, sq_d;
    logic [SW-1:0]                s_q, s_d;
    logic [RW-1:0]                rem_q, rem_d;
    logic [DATA_WIDTH-1:0]        root_q, root_d;
    logic [DATA_WIDTH-1:0]        len_q, len_d;
    logic [CW-1:0]                iter_q, iter_d;

    logic signed [SW-1:0]  w_xe, w_ye, w_ze, w_px, w_py, w_pz;
    logic [SW-1:0]         w_sum, w_sq_shift;
    logic [DATA_WIDTH-1:0] w_sq_len;
    logic [RW-1:0]         w_rem_sh, w_trial, w_rem_nx;
    logic                  w_ge, w_round;
    logic [DATA_WIDTH-1:0] w_root_nx, w_root_fin;
    logic                  w_unused;

    assign w_xe  = SW'(x_q);
    assign w_ye  = SW'(y_q);
    assign w_ze  = SW'(z_q);
    assign w_px  = w_xe * w_xe;
    assign w_py  = w_ye * w_ye;
    assign w_pz  = w_ze * w_ze;
    assign w_sum = $unsigned(w_px) + $unsigned(w_py) + $unsigned(w_pz);

    assign w_sq_shift = w_sum >> FRAC_BITS;
    assign w_sq_len   = (|w_sq_shift[SW-1:DATA_WIDTH]) ? '1 : w_sq_shift[DATA_WIDTH-1:0];

    // The partial remainder never exceeds twice the partial root, so its top two bits are zero before the shift.
    assign w_rem_sh  = {rem_q[RW-3:0], s_q[SW-1 -: 2]};
    assign w_trial   = {root_q, 2'b01};
    assign w_ge      = (w_rem_sh >= w_trial);
    assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nx = {root_q[DATA_WIDTH-2:0], w_ge};

    assign w_round    = (ROUND != 0) && (w_rem_nx > {2'b00, w_root_nx});
    assign w_root_fin = w_root_nx + {{(DATA_WIDTH-1){1'b0}}, w_round};
    assign w_unused   = &{1'b0, rem_q[RW-1 -: 2]};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        sq_d    = sq_q;
        s_d     = s_q;
        rem_d   = rem_q;
        root_d  = root_q;
        iter_d  = iter_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    x_d     = vec_x;
                    y_d     = vec_y;
                    z_d     = vec_z;
                    sq_d    = sq_mode;
                    state_d = SUM;
                end
            end
            SUM: begin
                s_d    = w_sum;
                rem_d  = '0;
                root_d = '0;
                iter_d = '0;
                if (sq_q) begin
                    len_d   = w_sq_len;
                    state_d = DONE;
                end else begin
                    state_d = ROOT;
                end
            end
            ROOT: begin
                s_d    = {s_q[SW-3:0], 2'b00};
                rem_d  = w_rem_nx;
                root_d = w_root_nx;
                iter_d = iter_q + CW'(1);
                if (iter_q == CW'(DATA_WIDTH - 1)) begin
                    len_d   = w_root_fin;
                    iter_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sq_q    <= 1'b0;
            s_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            len_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sq_q    <= sq_d;
            s_q     <= s_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            len_q   <= len_d;
            iter_q  <= iter_d;
        end
    end

    assign ready_in  = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign length    = len_q;

endmodule
`default_nettype wire

// File: tb/tb_vec3_norm_unit.sv
`default_nettype none
// =====================================================================
// tb_vec3_norm_unit : vector table, corner sequences and random sweep
//                     for 32-bit (floor and round) and 16-bit units
// Revision          : 1.0
// =====================================================================
module tb_vec3_norm_unit;
    localparam int LAT32 = 34;
    localparam int LAT16 = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] vx = '0, vy = '0, vz = '0;
    logic        vsq = 1'b0, vin = 1'b0, rout = 1'b1;
    logic        rdy32, vo32, rdy32r, vo32r;
    logic [31:0] len32, len32r;
    logic [15:0] wx = '0, wy = '0, wz = '0;
    logic        wsq = 1'b0, win = 1'b0, wout = 1'b1;
    logic        rdy16, vo16;
    logic [15:0] len16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
    } exp_t;
    exp_t sb32[$];
    logic [15:0] sb16[$];

    typedef struct {
        logic [31:0] x, y, z;
        logic        sq;
        logic [31:0] e0, e1;
        int          stall;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    vec3_norm_unit #(.DATA_WIDTH(32), .FRAC_BITS(16), .ROUND(0)) u32 (
        .clk(clk), .rst(rst), .vec_x(vx), .vec_y(vy), .vec_z(vz), .sq_mode(vsq),
        .valid_in(vin), .ready_in(rdy32), .length(len32), .valid_out(vo32), .ready_out(rout));
    vec3_norm_unit #(.DATA_WIDTH(32), .FRAC_BITS(16), .ROUND(1)) u32r (
        .clk(clk), .rst(rst), .vec_x(vx), .vec_y(vy), .vec_z(vz), .sq_mode(vsq),
        .valid_in(vin), .ready_in(rdy32r), .length(len32r), .valid_out(vo32r), .ready_out(rout));
    vec3_norm_unit #(.DATA_WIDTH(16), .FRAC_BITS(8), .ROUND(0)) u16 (
        .clk(clk), .rst(rst), .vec_x(wx), .vec_y(wy), .vec_z(wz), .sq_mode(wsq),
        .valid_in(win), .ready_in(rdy16), .length(len16), .valid_out(vo16), .ready_out(wout));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] isqrt(input logic [63:0] s);
        logic [63:0] r, t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= s) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input logic sq,
                                          input int dw, input int f, input bit rnd);
        logic [63:0] xs, ys, zs, s, r, v, maxv;
        if (dw == 16) begin
            xs = {{48{x[15]}}, x[15:0]};
            ys = {{48{y[15]}}, y[15:0]};
            zs = {{48{z[15]}}, z[15:0]};
        end else begin
            xs = {{32{x[31]}}, x};
            ys = {{32{y[31]}}, y};
            zs = {{32{z[31]}}, z};
        end
        s    = xs * xs + ys * ys + zs * zs;
        maxv = (64'd1 << dw) - 64'd1;
        if (sq) begin
            v = s >> f;
            if (v > maxv) v = maxv;
            return v[31:0];
        end
        r = isqrt(s);
        if (rnd && ((s - r * r) > r)) r = r + 64'd1;
        return r[31:0];
    endfunction

    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic sq, input logic [31:0] e0, input logic [31:0] e1, input int stall);
        int   n;
        exp_t p;
        n = 0;
        while (!rdy32 && n < 100) begin @(posedge clk); #1; n++; end
        vx = x; vy = y; vz = z; vsq = sq; vin = 1'b1; rout = (stall == 0);
        @(posedge clk); #1;
        vin = 1'b0; vx = $urandom; vy = $urandom; vz = $urandom; vsq = ~sq;
        p.e0 = e0; p.e1 = e1;
        sb32.push_back(p);
        n = 0;
        while (!vo32 && n < 200) begin @(posedge clk); #1; n++; end
        chk("latency32", 64'(n + 1), sq ? 64'd2 : 64'(LAT32));
        for (int i = 0; i < stall; i++) begin
            if (i == 3) begin vin = 1'b1; vx = 32'h0007_0000; vsq = 1'b0; end
            @(posedge clk); #1;
            vin = 1'b0;
            chk("stall_valid", {63'd0, vo32}, 64'd1);
            chk("stall_length", {32'd0, len32}, {32'd0, e0});
            chk("stall_ready_in", {63'd0, rdy32}, 64'd0);
        end
        rout = 1'b1;
        p = sb32.pop_front();
        chk("length32", {32'd0, len32}, {32'd0, p.e0});
        chk("length32_round", {32'd0, len32r}, {32'd0, p.e1});
        chk("valid32_round", {63'd0, vo32r}, 64'd1);
        @(posedge clk); #1;
        chk("idle_ready_in", {63'd0, rdy32}, 64'd1);
        chk("idle_valid_out", {63'd0, vo32}, 64'd0);
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         input logic sq, input logic [15:0] e);
        int n;
        n = 0;
        while (!rdy16 && n < 100) begin @(posedge clk); #1; n++; end
        wx = x; wy = y; wz = z; wsq = sq; win = 1'b1; wout = 1'b1;
        @(posedge clk); #1;
        win = 1'b0; wx = 16'($urandom); wy = 16'($urandom); wz = 16'($urandom);
        sb16.push_back(e);
        n = 0;
        while (!vo16 && n < 200) begin @(posedge clk); #1; n++; end
        chk("latency16", 64'(n + 1), sq ? 64'd2 : 64'(LAT16));
        chk("length16", {48'd0, len16}, {48'd0, sb16.pop_front()});
        @(posedge clk); #1;
        chk("idle16_valid_out", {63'd0, vo16}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y, z;
        logic        sq;
        int          seen;

        tbl[0] = '{32'h0003_0000, 32'h0004_0000, 32'h0, 1'b0, 32'h0005_0000, 32'h0005_0000, 0};
        tbl[1] = '{32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 1'b0, 32'h0003_0000, 32'h0003_0000, 0};
        tbl[2] = '{32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 1'b1, 32'h0009_0000, 32'h0009_0000, 0};
        tbl[3] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 0};
        tbl[4] = '{32'h1, 32'h1, 32'h1, 1'b0, 32'h1, 32'h2, 0};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h1, 32'h1, 0};
        tbl[6] = '{32'h0100_0000, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        tbl[7] = '{32'h0003_0000, 32'h0004_0000, 32'h0, 1'b1, 32'h0019_0000, 32'h0019_0000, 0};
        tbl[8] = '{32'hFFFD_0000, 32'hFFFC_0000, 32'h0, 1'b0, 32'h0005_0000, 32'h0005_0000, 10};

        // Asynchronous reset: outputs must settle before any clock edge.
        #1 rst = 1'b0;
        #1;
        chk("reset_length", {32'd0, len32}, 64'd0);
        chk("reset_valid_out", {63'd0, vo32}, 64'd0);
        chk("reset_ready_in", {63'd0, rdy32}, 64'd1);
        chk("reset_ready_in16", {63'd0, rdy16}, 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;

        foreach (tbl[i])
            run32(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].sq, tbl[i].e0, tbl[i].e1, tbl[i].stall);

        x = 32'h8000_0000;
        run32(x, x, x, 1'b0, model(x, x, x, 1'b0, 32, 16, 1'b0), model(x, x, x, 1'b0, 32, 16, 1'b1), 0);
        run32(x, x, x, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Reset five cycles into the root iterations.
        vx = 32'h0003_0000; vy = 32'h0004_0000; vz = '0; vsq = 1'b0; vin = 1'b1; rout = 1'b1;
        @(posedge clk); #1;
        vin = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midroot_valid_out", {63'd0, vo32}, 64'd0);
        chk("midroot_length", {32'd0, len32}, 64'd0);
        chk("midroot_ready_in", {63'd0, rdy32}, 64'd1);
        #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (vo32) seen++;
        end
        chk("midroot_no_stale_valid", 64'(seen), 64'd0);
        run32(32'h0003_0000, 32'h0004_0000, 32'h0, 1'b0, 32'h0005_0000, 32'h0005_0000, 0);

        for (int i = 0; i < 40; i++) begin
            x  = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
            y  = (i % 5 == 1) ? 32'h8000_0000 : $urandom;
            z  = (i % 3 == 2) ? 32'($urandom_range(0, 65535)) : $urandom;
            sq = 1'($urandom);
            run32(x, y, z, sq, model(x, y, z, sq, 32, 16, 1'b0), model(x, y, z, sq, 32, 16, 1'b1), 0);
        end

        run16(16'h0300, 16'h0400, 16'h0000, 1'b0, 16'h0500);
        run16(16'h1000, 16'h0000, 16'h0000, 1'b1, 16'hFFFF);
        run16(16'h8000, 16'h8000, 16'h8000, 1'b0, model(32'h8000, 32'h8000, 32'h8000, 1'b0, 16, 8, 1'b0)[15:0]);
        for (int i = 0; i < 40; i++) begin
            x  = {16'd0, 16'($urandom)};
            y  = (i % 4 == 0) ? 32'h8000 : {16'd0, 16'($urandom)};
            z  = {16'd0, 16'($urandom_range(0, 2047))};
            sq = 1'($urandom);
            run16(x[15:0], y[15:0], z[15:0], sq, model(x, y, z, sq, 16, 8, 1'b0)[15:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vec3_norm_unit.md
VEC3_NORM_UNIT -- requirements
Module: vec3_norm_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each signed input component and of the unsigned result (even, 8..32).
REQ-002 SHALL have parameter FRAC_BITS, default 16: fractional bits of components and result.
REQ-003 SHALL have parameter ROUND, default 0: 0 = floor square root, 1 = round-to-nearest square root.
REQ-004 SHALL have a single clock and an asynchronous active-low reset; there are no other clock or reset inputs.
REQ-005 Port list (clock and reset first):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- vec_x / vec_y / vec_z  in  DATA_WIDTH each  signed fixed-point components.
- sq_mode  in  1  1 = squared length, 0 = length.
- valid_in  in  1  input request.
- ready_in  out  1  unit can accept.
- length  out  DATA_WIDTH  unsigned fixed-point result.
- valid_out  out  1  result valid.
- ready_out  in  1  downstream accepts.

Function
REQ-006 SHALL implement a state machine IDLE -> SUM -> ROOT -> DONE -> IDLE.
REQ-007 ready_in SHALL be 1 only in IDLE.
REQ-008 Accept: valid_in && ready_in on a rising edge SHALL register vec_x, vec_y, vec_z and sq_mode, and move to SUM.
REQ-009 SUM (1 cycle) SHALL compute S = x*x + y*y + z*z, unsigned, 2*DATA_WIDTH bits, with 2*FRAC_BITS fractional bits, no truncation.
- S < 2^(2*DATA_WIDTH) for all inputs, so S never overflows.
REQ-010 After SUM:
- sq_mode=1: SHALL go to DONE with length = S >> FRAC_BITS, saturated to 2^DATA_WIDTH-1.
- sq_mode=0: SHALL go to ROOT.
REQ-011 ROOT SHALL run a digit-by-digit restoring integer square root of S.
- One result bit per cycle, MSB first, exactly DATA_WIDTH cycles, counted by an iteration counter.
- The result r = floor(sqrt(S)) has FRAC_BITS fractional bits and always fits DATA_WIDTH bits unsigned.
REQ-012 With ROUND=1, the result SHALL be r+1 when the final remainder S - r^2 > r, else r; no overflow is possible.
REQ-013 Latency from the accept edge to valid_out high:
- sq_mode=0: SHALL be DATA_WIDTH+2 cycles.
- sq_mode=1: SHALL be 2 cycles.
REQ-014 In DONE, valid_out SHALL be 1 and length SHALL hold stable until valid_out && ready_out; on that edge the unit SHALL return to IDLE.
REQ-015 ready_out low SHALL stall DONE indefinitely with no loss or change of the result.
REQ-016 valid_in asserted outside IDLE SHALL be ignored; no request is queued.
REQ-017 valid_out SHALL be 0 in IDLE, SUM and ROOT; length SHALL retain its last value outside DONE.
REQ-018 Inputs are don't-care except on the accept edge; input changes during SUM or ROOT SHALL NOT affect the result.
REQ-019 Throughput SHALL be at most one vector per DATA_WIDTH+3 cycles (length mode) or 3 cycles (squared mode), with ready_out held high.

Reset
REQ-020 Asserting rst low SHALL immediately, without waiting for clk, force:
- state IDLE, iteration counter 0;
- length = 0, valid_out = 0, ready_in = 1 (while rst stays low).
REQ-021 Reset during SUM, ROOT or DONE SHALL discard the in-flight vector; no valid_out pulse for it SHALL ever appear.
REQ-022 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification (DATA_WIDTH=32, FRAC_BITS=16 unless stated)
REQ-023 Pythagorean case:
- Input (0x00030000, 0x00040000, 0), sq_mode=0, ready_out=1 -> length = 0x00050000 with valid_out high exactly 34 cycles after accept.
- Input (0x00010000, 0x00020000, 0x00020000) -> 0x00030000.
- Same input with sq_mode=1 -> 0x00090000 after 2 cycles.
REQ-024 Zero and rounding (raw LSB values):
- (0, 0, 0) -> 0.
- (1, 1, 1) -> 1 with ROUND=0, and 2 with ROUND=1.
- (0xFFFFFFFF, 0, 0) -> 1.
REQ-025 Saturation: (0x01000000, 0, 0), sq_mode=1 -> length = 0xFFFFFFFF.
REQ-026 Backpressure:
- Hold ready_out=0 for 10 cycles after valid_out rises -> valid_out and length stable throughout, ready_in=0, and a valid_in pulse in that window is ignored.
- Raise ready_out -> IDLE on the next edge.
REQ-027 Reset mid-ROOT: assert rst 5 cycles into ROOT -> valid_out=0 and length=0 immediately, ready_in=1 after release, and the next vector (0x00030000, 0x00040000, 0) returns 0x00050000.
REQ-028 Randomised back-to-back sweep of signed components and modes against a floor/round sqrt reference model, including all components at -2^(DATA_WIDTH-1); repeat for DATA_WIDTH=16, FRAC_BITS=8 -> every result matches the model and the latency matches REQ-013.
